// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int ROWS       = 4;
  localparam int COLS       = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    RELEASE
  } state_t;

  // Index of the lowest asserted column; simultaneous columns resolve low.
  function automatic logic [1:0] lowest_col(input logic [COLS-1:0] c);
    logic [1:0] idx;
    if (c[0])      idx = 2'd0;
    else if (c[1]) idx = 2'd1;
    else if (c[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous column returns.
module keypad_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages; reset clears both so no stale column is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-hot row drive, column debounce, key encode and
// valid/ack handoff with sticky overrun and level interrupt.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [COLS-1:0]       col,
  output logic [ROWS-1:0]       row,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ack,
  output logic                  overrun,
  output logic                  irq
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [COLS-1:0]       col_s;
  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [DEB_W-1:0]      deb_cnt;
  logic [1:0]            row_idx;
  logic [COLS-1:0]       pattern;
  logic                  accept;
  logic [KEY_CODE_W-1:0] new_code;

  keypad_sync2 #(
    .W (COLS)
  ) u_sync (
    .clk   (clk),
    .rst_n (RSTn),
    .d     (col),
    .q     (col_s)
  );

  assign accept   = (state == DEBOUNCE) && (col_s == pattern) && (deb_cnt == DEB_LAST);
  assign new_code = {row_idx, lowest_col(pattern)};
  assign irq      = key_valid;

  // Scan / debounce / release sequencing with row drive and dwell counters.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state   <= SCAN;
      div_cnt <= '0;
      deb_cnt <= '0;
      row_idx <= '0;
      row     <= {{(ROWS-1){1'b0}}, 1'b1};
      pattern <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (div_cnt == DIV_LAST) begin
            if (col_s != '0) begin
              pattern <= col_s;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              div_cnt <= '0;
              row_idx <= row_idx + 2'd1;
              row     <= {row[ROWS-2:0], row[ROWS-1]};
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        DEBOUNCE: begin
          if (col_s != pattern) begin
            // Bounce: resume scanning the same row from the start of its dwell.
            state   <= SCAN;
            div_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= RELEASE;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        RELEASE: begin
          if (col_s != '0) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= SCAN;
            deb_cnt <= '0;
            div_cnt <= '0;
            row_idx <= row_idx + 2'd1;
            row     <= {row[ROWS-2:0], row[ROWS-1]};
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  // Key handoff: ack clears the held code; an accept coinciding with ack
  // still loads, otherwise an accept while valid only flags overrun.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
      if (accept) begin
        if (!key_valid || key_ack) begin
          key_code  <= new_code;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
